// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and defaults for the fetch->decode instruction queue.
// fetch_data_t is the 66-bit record that fetch hands to decode.
package fetch_decode_queue_pkg;

  localparam int FETCHQ_DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr_;
    logic [31:0] pcplus4;
    logic        exception_instr;
    logic        in_delay_slot;
  } fetch_data_t;

  localparam int FETCH_DATA_W = $bits(fetch_data_t);

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle between fetch (master) and the queue (slave); decode-side
// signals ride in the same bundle so the queue sees one port.
interface fetch_decode_queue_if
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             flush;
  logic             in_valid;
  fetch_data_t      in_data;
  logic             in_ready;
  logic             out_valid;
  fetch_data_t      out_data;
  logic             out_ready;
  logic [PTR_W:0]   count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/fetch_decode_queue_ram.sv
// DEPTH x 66 storage for the queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fetch_decode_queue_ram
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  fetch_data_t       wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output fetch_data_t       rdata_o
);

  fetch_data_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// Circular FIFO between fetch and decode. Pointers, occupancy and flush live
// here; storage is in fetch_decode_queue_ram. Flush beats push and pop.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  fetch_decode_queue_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  logic             not_full, not_empty;
  fetch_data_t      head_data;

  // Flags come only from registered occupancy, so in_ready never depends on out_ready.
  assign not_full  = (count_q != FULL_COUNT);
  assign not_empty = (count_q != '0);

  assign push = bus.in_valid && not_full && !bus.flush;
  assign pop  = not_empty && bus.out_ready && !bus.flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_decode_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  // Stale storage must never leak out, so the head is masked when empty.
  assign bus.in_ready  = not_full;
  assign bus.out_valid = not_empty;
  assign bus.out_data  = not_empty ? head_data : '0;
  assign bus.count     = count_q;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
    count_q <= FULL_COUNT);
  a_valid_matches_count: assert property (@(posedge clk) disable iff (!resetn)
    bus.out_valid == (count_q != '0));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!resetn)
    !(pop && count_q == '0));
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed + random bench for fetch_decode_queue against a queue-based model.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;
  fetch_data_t model_q[$];

  fetch_decode_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    fetch_data_t exp_head;
    exp_head = (model_q.size() != 0) ? model_q[0] : '0;
    check({tag, ".count"},     66'(bus.count),     66'(model_q.size()));
    check({tag, ".out_valid"}, 66'(bus.out_valid), 66'(model_q.size() != 0));
    check({tag, ".in_ready"},  66'(bus.in_ready),  66'(model_q.size() != DEPTH));
    check({tag, ".out_data"},  66'(bus.out_data),  66'(exp_head));
  endtask

  // Drive one cycle, check pre-edge outputs, then apply the queue rules to the model.
  task automatic cycle(input string tag, input logic v, input fetch_data_t d,
                       input logic rdy, input logic fl);
    logic acc_push, acc_pop;
    fetch_data_t popped;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(negedge clk);
    check_outputs(tag);
    acc_push = v && (model_q.size() < DEPTH) && !fl;
    acc_pop  = rdy && (model_q.size() > 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      model_q.delete();
    end else begin
      if (acc_pop) popped = model_q.pop_front();
      if (acc_push) model_q.push_back(d);
    end
    $display("txn %-10s v=%0b rdy=%0b fl=%0b instr=%h pc=%h -> model_count=%0d",
             tag, v, rdy, fl, d.instr_, d.pcplus4, model_q.size());
  endtask

  function automatic fetch_data_t mk(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic ex, input logic ds);
    fetch_data_t r;
    r.instr_ = ins;
    r.pcplus4 = pc;
    r.exception_instr = ex;
    r.in_delay_slot = ds;
    return r;
  endfunction

  function automatic fetch_data_t rnd_rec();
    return mk($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  initial begin
    fetch_data_t idle;
    fetch_data_t flag_rec;
    n_cmp = 0;
    n_err = 0;
    idle = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    resetn        = 1'b0;

    // Reset then idle
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("in_reset");
    resetn = 1'b1;
    cycle("idle", 1'b0, idle, 1'b0, 1'b0);

    // Fill with out_ready low, hold a fifth push, then drain
    for (int i = 0; i < 4; i++)
      cycle("fill", 1'b1, mk(32'h24020001 + i, 32'hBFC00004 + 32'(4 * i), 1'b0, 1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      cycle("hold5", 1'b1, mk(32'h24020005, 32'hBFC00014, 1'b0, 1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle("drain", 1'b0, idle, 1'b1, 1'b0);
    cycle("drained", 1'b0, idle, 1'b1, 1'b0);

    // Streaming across two pointer wraps
    for (int i = 0; i < 10; i++)
      cycle("stream", 1'b1, mk(32'h3C000000 + i, 32'hBFC00100 + 32'(4 * i), 1'b0, 1'b0), 1'b1, 1'b0);
    cycle("stream_end", 1'b0, idle, 1'b1, 1'b0);
    cycle("stream_idle", 1'b0, idle, 1'b0, 1'b0);

    // Flush with concurrent push and pop
    for (int i = 0; i < 3; i++)
      cycle("pre_flush", 1'b1, mk(32'h24030010 + i, 32'hBFC00200 + 32'(4 * i), 1'b0, 1'b0), 1'b0, 1'b0);
    cycle("flush", 1'b1, mk(32'hDEADBEEF, 32'hBFC00300, 1'b1, 1'b0), 1'b1, 1'b1);
    cycle("post_flush", 1'b1, mk(32'h00000000, 32'hBFC00380, 1'b0, 1'b0), 1'b0, 1'b0);
    cycle("vec_head", 1'b0, idle, 1'b0, 1'b0);
    cycle("vec_pop", 1'b0, idle, 1'b1, 1'b0);

    // Flags travel unmodified
    flag_rec = mk(32'h0000000C, 32'hBFC00006, 1'b1, 1'b1);
    cycle("flag_push", 1'b1, flag_rec, 1'b0, 1'b0);
    check("flag_head", 66'(bus.out_data), 66'(flag_rec));
    cycle("flag_pop", 1'b0, idle, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries held
    cycle("ar_push0", 1'b1, mk(32'h24040001, 32'hBFC00404, 1'b0, 1'b0), 1'b0, 1'b0);
    cycle("ar_push1", 1'b1, mk(32'h24040002, 32'hBFC00408, 1'b0, 1'b0), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    check("ar_before.count", 66'(bus.count), 66'(2));
    resetn = 1'b0;
    #1;
    model_q.delete();
    check_outputs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle("after_rst", 1'b0, idle, 1'b0, 1'b0);
    cycle("after_rst2", 1'b0, idle, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++)
      cycle("random", 1'($urandom_range(0, 99) < 60), rnd_rec(),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 4));
    cycle("final", 1'b0, idle, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
